// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use stall control and
//                optional writeback bypass (macro ID_EX_WB_BYPASS_EN).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        flush,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic [19:0] id_imm,
    input  logic [15:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic        id_reg_write,
    input  logic        id_mem_to_reg,
    input  logic        id_mem_write,
    input  logic [3:0]  id_alu_control,
    input  logic [1:0]  id_imm_src,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rn,
    output logic [4:0]  ex_rm,
    output logic [19:0] ex_imm,
    output logic [15:0] ex_pc,
    output logic [31:0] ex_srcA,
    output logic [31:0] ex_srcB,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic [3:0]  ex_alu_control,
    output logic [1:0]  ex_imm_src,
    output logic        stall,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic        w_hazard;
    logic        w_bubble;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;

    // A load in EX whose destination feeds the ID instruction; r0 never counts.
    assign w_hazard = id_valid & ex_valid & ex_mem_to_reg & (ex_rd != 5'd0) &
                      ((ex_rd == id_rn) | (ex_rd == id_rm));

    assign stall    = ~rst & ~flush & (r_state == RUN) & w_hazard;
    assign w_bubble = flush | stall | ~id_valid;

`ifdef ID_EX_WB_BYPASS_EN
    assign w_src_a = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rn)) ? wb_data : id_rd1;
    assign w_src_b = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rm)) ? wb_data : id_rd2;
`else
    logic w_wb_unused;
    assign w_wb_unused = ^{wb_we, wb_rd, wb_data};
    assign w_src_a     = id_rd1;
    assign w_src_b     = id_rd2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= RUN;
            stall_count    <= 16'd0;
            ex_valid       <= 1'b0;
            ex_rd          <= 5'd0;
            ex_rn          <= 5'd0;
            ex_rm          <= 5'd0;
            ex_imm         <= 20'd0;
            ex_pc          <= 16'd0;
            ex_srcA        <= 32'd0;
            ex_srcB        <= 32'd0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_alu_control <= 4'd0;
            ex_imm_src     <= 2'd0;
        end else begin
            if (stall) begin
                r_state <= HOLD;
                if (stall_count != STALL_SAT)
                    stall_count <= stall_count + 16'd1;
            end else begin
                r_state <= RUN;
            end

            if (w_bubble) begin
                ex_valid       <= 1'b0;
                ex_rd          <= 5'd0;
                ex_rn          <= 5'd0;
                ex_rm          <= 5'd0;
                ex_imm         <= 20'd0;
                ex_pc          <= 16'd0;
                ex_srcA        <= 32'd0;
                ex_srcB        <= 32'd0;
                ex_reg_write   <= 1'b0;
                ex_mem_to_reg  <= 1'b0;
                ex_mem_write   <= 1'b0;
                ex_alu_control <= 4'd0;
                ex_imm_src     <= 2'd0;
            end else begin
                ex_valid       <= 1'b1;
                ex_rd          <= id_rd;
                ex_rn          <= id_rn;
                ex_rm          <= id_rm;
                ex_imm         <= id_imm;
                ex_pc          <= id_pc;
                ex_srcA        <= w_src_a;
                ex_srcB        <= w_src_b;
                ex_reg_write   <= id_reg_write;
                ex_mem_to_reg  <= id_mem_to_reg;
                ex_mem_write   <= id_mem_write;
                ex_alu_control <= id_alu_control;
                ex_imm_src     <= id_imm_src;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (vector table + queue).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam logic [15:0] SAT = 16'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, flush;
    logic [4:0]  id_rd, id_rn, id_rm;
    logic [19:0] id_imm;
    logic [15:0] id_pc;
    logic [31:0] id_rd1, id_rd2;
    logic        id_reg_write, id_mem_to_reg, id_mem_write;
    logic [3:0]  id_alu_control;
    logic [1:0]  id_imm_src;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [4:0]  ex_rd, ex_rn, ex_rm;
    logic [19:0] ex_imm;
    logic [15:0] ex_pc;
    logic [31:0] ex_srcA, ex_srcB;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic [3:0]  ex_alu_control;
    logic [1:0]  ex_imm_src;
    logic        stall;
    logic [15:0] stall_count;

    id_ex_stage #(.STALL_SAT(SAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_imm(id_imm), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_control(id_alu_control), .id_imm_src(id_imm_src),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_srcA(ex_srcA), .ex_srcB(ex_srcB),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_control(ex_alu_control),
        .ex_imm_src(ex_imm_src), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, flush, mtr;
        logic [4:0]  rd, rn, rm;
        logic [3:0]  alu;
        logic [31:0] rd1, rd2;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_stall, exp_valid;
        logic [4:0]  exp_rd;
        logic [3:0]  exp_alu;
        logic [31:0] exp_a, exp_b;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [31:0] a, b;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t v(input logic valid, input logic fl, input logic mtr,
                               input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                               input logic [3:0] alu, input logic [31:0] rd1,
                               input logic st, input logic ev, input logic [15:0] cnt);
        vec_t r;
        r.valid = valid; r.flush = fl; r.mtr = mtr;
        r.rd = rd; r.rn = rn; r.rm = rm; r.alu = alu;
        r.rd1 = rd1; r.rd2 = rd1 ^ 32'hFFFF_0000;
        r.wb_we = 1'b0; r.wb_rd = 5'd0; r.wb_data = 32'd0;
        r.exp_stall = st; r.exp_valid = ev;
        r.exp_rd  = ev ? rd  : 5'd0;
        r.exp_alu = ev ? alu : 4'd0;
        r.exp_a   = ev ? r.rd1 : 32'd0;
        r.exp_b   = ev ? r.rd2 : 32'd0;
        r.exp_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_valid = x.valid; flush = x.flush; id_mem_to_reg = x.mtr;
        id_rd = x.rd; id_rn = x.rn; id_rm = x.rm; id_alu_control = x.alu;
        id_rd1 = x.rd1; id_rd2 = x.rd2;
        id_reg_write = x.valid; id_mem_write = 1'b0;
        id_imm = {15'd0, x.rd}; id_pc = {12'd0, x.alu}; id_imm_src = 2'd1;
        wb_we = x.wb_we; wb_rd = x.wb_rd; wb_data = x.wb_data;
    endtask

    task automatic step(input string name, input vec_t x);
        exp_t e;
        @(negedge clk);
        apply(x);
        #1;
        chk({name, ".stall"}, {31'd0, stall}, {31'd0, x.exp_stall});
        e.valid = x.exp_valid; e.rd = x.exp_rd; e.alu = x.exp_alu;
        e.a = x.exp_a; e.b = x.exp_b; e.cnt = x.exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({name, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        chk({name, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
        chk({name, ".ex_alu"}, {28'd0, ex_alu_control}, {28'd0, e.alu});
        chk({name, ".ex_srcA"}, ex_srcA, e.a);
        chk({name, ".ex_srcB"}, ex_srcB, e.b);
        chk({name, ".count"}, {16'd0, stall_count}, {16'd0, e.cnt});
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".ex_any"}, {31'd0, |{ex_valid, ex_rd, ex_rn, ex_rm, ex_imm, ex_pc, ex_srcA,
            ex_srcB, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_control, ex_imm_src}}, 32'd0);
        chk({name, ".stall"}, {31'd0, stall}, 32'd0);
        chk({name, ".count"}, {16'd0, stall_count}, 32'd0);
    endtask

    task automatic randomize_inputs();
        id_valid = 1'b1; flush = 1'b0;
        id_rd = 5'($urandom); id_rn = 5'($urandom); id_rm = 5'($urandom);
        id_imm = 20'($urandom); id_pc = 16'($urandom);
        id_rd1 = $urandom; id_rd2 = $urandom;
        id_reg_write = 1'b1; id_mem_to_reg = 1'b1; id_mem_write = 1'($urandom);
        id_alu_control = 4'($urandom); id_imm_src = 2'($urandom);
        wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
    endtask

    vec_t tbl[18];
    vec_t bv;

    initial begin
        tbl[0]  = v(1,0,0, 5'd1, 5'd2, 5'd3, 4'd1,  32'h1111_0001, 0,1,16'd0);
        tbl[1]  = v(1,0,0, 5'd2, 5'd1, 5'd3, 4'd2,  32'h1111_0002, 0,1,16'd0);
        tbl[2]  = v(1,0,0, 5'd3, 5'd1, 5'd2, 4'd3,  32'h1111_0003, 0,1,16'd0);
        tbl[3]  = v(1,0,0, 5'd4, 5'd3, 5'd1, 4'd4,  32'h1111_0004, 0,1,16'd0);
        tbl[4]  = v(1,0,1, 5'd5, 5'd1, 5'd2, 4'd5,  32'h1111_0005, 0,1,16'd0);
        tbl[5]  = v(1,0,0, 5'd8, 5'd5, 5'd1, 4'd6,  32'h1111_0006, 1,0,16'd1);
        tbl[6]  = v(1,0,0, 5'd8, 5'd5, 5'd1, 4'd6,  32'h1111_0006, 0,1,16'd1);
        tbl[7]  = v(1,0,1, 5'd0, 5'd1, 5'd2, 4'd7,  32'h1111_0007, 0,1,16'd1);
        tbl[8]  = v(1,0,0, 5'd9, 5'd0, 5'd0, 4'd8,  32'h1111_0008, 0,1,16'd1);
        tbl[9]  = v(1,0,1, 5'd3, 5'd1, 5'd2, 4'd9,  32'h1111_0009, 0,1,16'd1);
        tbl[10] = v(1,1,0, 5'd10,5'd1, 5'd3, 4'd10, 32'h1111_000A, 0,0,16'd1);
        tbl[11] = v(1,0,0, 5'd10,5'd1, 5'd3, 4'd11, 32'h1111_000B, 0,1,16'd1);
        tbl[12] = v(0,0,0, 5'd11,5'd10,5'd10,4'd12, 32'h1111_000C, 0,0,16'd1);
        tbl[13] = v(1,0,1, 5'd4, 5'd1, 5'd2, 4'd13, 32'h1111_000D, 0,1,16'd1);
        tbl[14] = v(1,0,0, 5'd12,5'd2, 5'd4, 4'd14, 32'h1111_000E, 1,0,16'd2);
        tbl[15] = v(1,0,0, 5'd12,5'd2, 5'd4, 4'd14, 32'h1111_000E, 0,1,16'd2);
        tbl[16] = v(1,0,1, 5'd6, 5'd1, 5'd2, 4'd15, 32'h1111_000F, 0,1,16'd2);
        tbl[17] = v(0,0,0, 5'd13,5'd6, 5'd6, 4'd1,  32'h1111_0010, 0,0,16'd2);

        // Reset asserted from time zero with random inputs, checked before any edge.
        randomize_inputs();
        #2;
        chk_reset("rst_init");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset between edges while EX holds a valid instruction.
        step("pre_async", v(1,0,1,5'd5,5'd1,5'd2,4'd3,32'hA5A5_0001,0,1,16'd2));
        @(negedge clk);
        apply(v(1,0,0,5'd7,5'd5,5'd1,4'd2,32'hA5A5_0002,1,0,16'd3));
        #1;
        chk("mid_stall.stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        @(negedge clk);
        rst = 1'b0;
        // First rising edge after release captures; HOLD was discarded so no stall.
        step("post_rst", v(1,0,0,5'd7,5'd5,5'd1,4'd2,32'hA5A5_0002,0,1,16'd0));

        // Flush arriving in HOLD still yields a bubble and returns to RUN.
        step("hf_load", v(1,0,1,5'd5,5'd1,5'd2,4'd3,32'hB0B0_0001,0,1,16'd0));
        step("hf_stall", v(1,0,0,5'd8,5'd5,5'd5,4'd4,32'hB0B0_0002,1,0,16'd1));
        step("hf_flush", v(1,1,0,5'd8,5'd5,5'd5,4'd4,32'hB0B0_0002,0,0,16'd1));
        step("hf_after", v(1,0,0,5'd8,5'd5,5'd5,4'd4,32'hB0B0_0002,0,1,16'd1));

        // Back-to-back dependent loads: every RUN cycle stalls once, count saturates.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step("sat_seed", v(1,0,1,5'd5,5'd1,5'd2,4'd1,32'hC0C0_0000,0,1,16'd0));
        for (int i = 0; i < 25; i++) begin
            logic [15:0] ec;
            ec = (i + 1 > int'(SAT)) ? SAT : 16'(i + 1);
            step($sformatf("sat%0d_s", i), v(1,0,1,5'd5,5'd5,5'd5,4'd2,32'hC0C0_0001,1,0,ec));
            step($sformatf("sat%0d_h", i), v(1,0,1,5'd5,5'd5,5'd5,4'd2,32'hC0C0_0001,0,1,ec));
        end

        // Writeback bypass onto both sources.
        bv = v(1,0,0,5'd1,5'd7,5'd7,4'd3,32'd0,0,1,SAT);
        bv.wb_we = 1'b1; bv.wb_rd = 5'd7; bv.wb_data = 32'hDEAD_BEEF;
`ifdef ID_EX_WB_BYPASS_EN
        bv.exp_a = 32'hDEAD_BEEF;
        bv.exp_b = 32'hDEAD_BEEF;
`else
        bv.exp_a = 32'd0;
        bv.exp_b = 32'hFFFF_0000;
`endif
        step("bypass7", bv);
        bv = v(1,0,0,5'd1,5'd0,5'd0,4'd3,32'h0000_0055,0,1,SAT);
        bv.wb_we = 1'b1; bv.wb_rd = 5'd0; bv.wb_data = 32'hDEAD_BEEF;
        step("bypass_r0", bv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising edge; rst  input  1  reset, asynchronous, active-high.
REQ-002 SHALL have: id_valid  input  1  decode slot holds a real instruction; flush  input  1  kill younger work (taken branch).
REQ-003 SHALL have: id_rd, id_rn, id_rm  input  5 each  decoded register fields; id_imm  input  20  immediate, zero-extended upstream; id_pc  input  16  instruction PC.
REQ-004 SHALL have: id_rd1, id_rd2  input  32 each  register-file read data for rn/rm.
REQ-005 SHALL have: id_reg_write, id_mem_to_reg, id_mem_write  input  1 each; id_alu_control  input  4; id_imm_src  input  2  Control_Unit outputs.
REQ-006 SHALL have: wb_we  input  1; wb_rd  input  5; wb_data  input  32  writeback port, same values driven to the register bank.
REQ-007 SHALL have: ex_valid  output  1; ex_rd, ex_rn, ex_rm  output  5; ex_imm  output  20; ex_pc  output  16; ex_srcA, ex_srcB  output  32; ex_reg_write, ex_mem_to_reg, ex_mem_write  output  1; ex_alu_control  output  4; ex_imm_src  output  2  registered EX-stage copies.
REQ-008 SHALL have: stall  output  1  hold PC and IF/ID register this cycle; stall_count  output  16  load-use stall event counter.

Function
REQ-009 SHALL register all ex_* outputs on rising clk; latency ID to EX exactly 1 cycle.
REQ-010 Bubble SHALL mean ex_valid=0 and ex_reg_write=ex_mem_to_reg=ex_mem_write=0, ex_alu_control=0; data fields don't-care but SHALL load 0.
REQ-011 Hazard SHALL be: id_valid & ex_valid & ex_mem_to_reg & ex_rd!=0 & (ex_rd==id_rn | ex_rd==id_rm).
REQ-012 FSM states RUN, HOLD; reset state RUN.
REQ-013 RUN, hazard, no flush: stall=1 combinationally same cycle, next edge loads bubble, go HOLD, stall_count increments.
REQ-014 RUN, no hazard, no flush: next edge captures ID inputs (ex_valid=id_valid), stay RUN.
REQ-015 HOLD: stall=0 regardless of hazard term, captures ID inputs, return RUN; stall never exceeds one consecutive cycle.
REQ-016 flush=1 in any state: stall=0, next edge loads bubble, next state RUN, stall_count unchanged; flush has priority over hazard.
REQ-017 Register r0 SHALL never trigger a hazard or a bypass.
REQ-018 stall_count SHALL saturate at 16'hFFFF, no wrap.
REQ-019 id_valid=0 without flush SHALL load a bubble (ex_valid=0) with no stall.

Reset
REQ-020 rst=1 SHALL immediately (asynchronously) force every ex_* output to 0, ex_valid=0, stall_count=0, FSM=RUN.
REQ-021 stall SHALL be 0 while rst=1; rst mid-stall drops stall the same cycle and discards HOLD.
REQ-022 First capture after rst release SHALL occur on the first rising clk with rst=0.

Configuration
REQ-023 Macro ID_EX_WB_BYPASS_EN SHALL select writeback bypass.
REQ-024 Defined: capture value of ex_srcA = wb_data when wb_we & wb_rd!=0 & wb_rd==id_rn, else id_rd1; same for ex_srcB with id_rm/id_rd2.
REQ-025 Undefined: ex_srcA=id_rd1, ex_srcB=id_rd2 unconditionally; wb_* ports present but unused.

Verification
REQ-026 Reset: rst=1 with random inputs -> all outputs 0 within same cycle, stall_count=0.
REQ-027 Load-use: EX holds load ex_rd=5, ID id_rn=5 valid -> stall=1 one cycle, next ex_valid=0, then ID instruction captured, stall_count=1.
REQ-028 r0 and flush: EX load ex_rd=0, ID rn=0 -> no stall; EX load ex_rd=3, ID rm=3 with flush=1 -> stall=0, bubble, count unchanged.
REQ-029 Bypass (macro defined): wb_we=1, wb_rd=7, wb_data=32'hDEADBEEF, id_rn=7, id_rd1=0 -> ex_srcA=32'hDEADBEEF; macro undefined -> ex_srcA=0.
REQ-030 Saturation: force 65536 load-use events -> stall_count holds 16'hFFFF.
REQ-031 Plain flow: 4 back-to-back valid ALU ops, id_alu_control 1..4 -> ex_alu_control 1..4 one cycle later, stall never asserted.
